bus_turn_arbiter: RTL and testbench
===================================

BUS_TURN_ARBITER -- requirements
Module: bus_turn_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, the maximum consecutive cycles one requester may own the bus (legal 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port req, input, 4, per-requester bus request; bit k belongs to requester k.
REQ-005 The block SHALL have port enable, output, 4, one-hot-or-zero drive enables, bit k wired to the enable of requester k's Tri_State_Buffer on the shared line.
REQ-006 The block SHALL have port owner, output, 2, binary index of the current owner; valid only while busy=1.
REQ-007 The block SHALL have port busy, output, 1, high while any enable bit is high.

Function
REQ-008 The block SHALL implement states IDLE, OWN and TURN.
REQ-009 enable, owner and busy SHALL be registered outputs; no combinational path from req to any output.
REQ-010 At most one enable bit SHALL be high in any cycle; the bus floats (enable=0) in IDLE and TURN.
REQ-011 The block SHALL hold a 2-bit last-owner pointer; arbitration grants the first requesting index searching last+1, last+2, last+3, last (mod 4).
REQ-012 IDLE: if req!=0 at a clock edge, next state OWN, enable=one-hot(winner), owner=winner, last=winner, hold counter=0; else stay IDLE.
REQ-013 Grant latency SHALL be exactly one cycle: req sampled at edge N, enable visible after edge N.
REQ-014 OWN: hold counter SHALL increment by 1 each cycle owned (8-bit, no wrap within legal MAX_HOLD).
REQ-015 OWN SHALL exit to TURN at the edge where req[owner]=0 or hold counter = MAX_HOLD-1, whichever comes first; owner therefore drives for at most MAX_HOLD cycles.
REQ-016 TURN SHALL last exactly one cycle with enable=0 and busy=0 (contention-free turnaround).
REQ-017 TURN: if req!=0, next state OWN with arbitration per REQ-011/REQ-012; else next state IDLE.
REQ-018 A requester pre-empted by MAX_HOLD that keeps requesting SHALL be regranted only after all other active requesters get a turn (fall-out of REQ-011).
REQ-019 If only the pre-empted requester is active, it SHALL be regranted after the single TURN cycle.
REQ-020 req changes of non-owners during OWN SHALL not affect enable until the next arbitration.
REQ-021 req[owner] deasserting in the same cycle another bit asserts SHALL still take TURN before the new grant (no back-to-back drive).

Reset
REQ-022 While reset=1, state SHALL be IDLE, enable=4'b0000, owner=2'b00, busy=0, hold counter=0, last=2'b11 (requester 0 wins first), asynchronously, irrespective of clk.
REQ-023 Reset asserted in OWN or TURN SHALL drop enable to 0 immediately; after deassertion the first arbitration SHALL again favour requester 0.
REQ-024 Reset deassertion SHALL take effect at the next rising clk edge; req sampled at that edge SHALL be arbitrated normally.

Verification
REQ-025 Single requester: reset, req=4'b0100 held 3 cycles then 0 -> enable=4'b0100 one cycle after req, for 3 cycles; then one TURN cycle at 0; then IDLE, busy=0.
REQ-026 Round-robin: req=4'b1111 held, MAX_HOLD=8 -> owners in order 0,1,2,3,0; each enable high exactly 8 cycles; one zero cycle between each tenure.
REQ-027 Pre-emption alone: req=4'b0010 held 20 cycles -> enable=4'b0010 for 8, 0 for 1, 4'b0010 for 8, 0 for 1, then remaining cycles, no overlap.
REQ-028 Swap same cycle: owner 0 drops req[0] while req[3] rises -> one cycle enable=0, then enable=4'b1000; no cycle with two enable bits high.
REQ-029 Mid-tenure reset: requester 2 owning, assert reset asynchronously between edges -> enable=0 immediately; release with req=4'b0101 -> requester 0 granted first.
REQ-030 All scenarios SHALL run an assertion checking enable is one-hot-or-zero every cycle and zero in the cycle after any enable bit falls.

Source files
------------

// File: rtl/bus_turn_arbiter.sv
// Round-robin owner arbiter for a shared tri-state line: grants one requester at a time,
// caps each tenure at MAX_HOLD cycles and inserts a one-cycle turnaround between owners.
module bus_turn_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] enable,
  output logic [1:0] owner,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [1:0] last;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       any_req;

  // Search last+4 down to last+1 so the nearest requester after last wins,
  // with last itself considered only when nobody else is asking.
  always_comb begin
    winner  = last;
    idx     = last;
    any_req = |req;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) winner = idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      enable   <= 4'b0000;
      owner    <= 2'b00;
      busy     <= 1'b0;
      hold_cnt <= 8'd0;
      last     <= 2'b11;
    end else begin
      case (state)
        IDLE, TURN: begin
          if (any_req) begin
            state    <= OWN;
            enable   <= 4'b0001 << winner;
            owner    <= winner;
            busy     <= 1'b1;
            last     <= winner;
            hold_cnt <= 8'd0;
          end else begin
            state  <= IDLE;
            enable <= 4'b0000;
            busy   <= 1'b0;
          end
        end
        OWN: begin
          // Either release path goes through TURN so two drivers never overlap.
          if (!req[owner] || hold_cnt == HOLD_LAST) begin
            state  <= TURN;
            enable <= 4'b0000;
            busy   <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          enable <= 4'b0000;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_turn_arbiter.sv
// Scoreboard bench for bus_turn_arbiter: stimulus queues hand-computed enables per cycle,
// a monitor pops and compares them, and a protocol checker watches enable every cycle.
module tb_bus_turn_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] enable;
  logic [1:0] owner;
  logic       busy;

  typedef struct {
    logic [3:0] en;
    logic [1:0] own;
    logic       bsy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] prev_en = 4'b0000;

  bus_turn_arbiter #(.MAX_HOLD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .enable(enable),
    .owner (owner),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
    end
  endtask

  task automatic push_exp(input logic [3:0] e);
    exp_t x;
    x.en  = e;
    x.bsy = |e;
    case (e)
      4'b0010: x.own = 2'd1;
      4'b0100: x.own = 2'd2;
      4'b1000: x.own = 2'd3;
      default: x.own = 2'd0;
    endcase
    exp_q.push_back(x);
  endtask

  // One cycle of stimulus: drive req away from the edge and queue the enable expected after it.
  task automatic apply_stimulus(input logic [3:0] r, input logic [3:0] e);
    @(negedge clk);
    req = r;
    push_exp(e);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0000;
    @(negedge clk);
    check_output("reset_enable", {4'b0, enable}, 8'h00);
    check_output("reset_owner", {6'b0, owner}, 8'h00);
    check_output("reset_busy", {7'b0, busy}, 8'h00);
    reset = 1'b0;
  endtask

  always @(posedge clk) begin : monitor
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check_output("enable", {4'b0, enable}, {4'b0, x.en});
      check_output("busy", {7'b0, busy}, {7'b0, x.bsy});
      if (x.bsy) check_output("owner", {6'b0, owner}, {6'b0, x.own});
    end
  end

  // Protocol watch: one-hot-or-zero enable, and a full zero cycle after any bit falls.
  always @(posedge clk) begin : protocol
    #1;
    check_output("enable_onehot0", {7'b0, $onehot0(enable)}, 8'h01);
    if ((prev_en & ~enable) != 4'b0000)
      check_output("enable_gap", {4'b0, enable}, 8'h00);
    prev_en = enable;
  end

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    #3;
    check_output("por_enable", {4'b0, enable}, 8'h00);
    check_output("por_busy", {7'b0, busy}, 8'h00);
    reset_dut();

    // Single requester 2 for three cycles, then TURN, then IDLE.
    apply_stimulus(4'b0000, 4'b0000);
    repeat (3) apply_stimulus(4'b0100, 4'b0100);
    apply_stimulus(4'b0000, 4'b0000);
    apply_stimulus(4'b0000, 4'b0000);

    // All four requesting: tenures of 8 in order 0,1,2,3,0 separated by one TURN cycle.
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      repeat (8) apply_stimulus(4'b1111, 4'b0001 << (k % 4));
      apply_stimulus(4'b1111, 4'b0000);
    end
    apply_stimulus(4'b0000, 4'b0000);

    // Lone requester 1 held 20 cycles: pre-empted and regranted after one TURN.
    reset_dut();
    repeat (8) apply_stimulus(4'b0010, 4'b0010);
    apply_stimulus(4'b0010, 4'b0000);
    repeat (8) apply_stimulus(4'b0010, 4'b0010);
    apply_stimulus(4'b0010, 4'b0000);
    repeat (2) apply_stimulus(4'b0010, 4'b0010);
    apply_stimulus(4'b0000, 4'b0000);
    apply_stimulus(4'b0000, 4'b0000);

    // Non-owner noise is ignored; owner 0 drops as requester 3 rises -> TURN then grant 3.
    reset_dut();
    apply_stimulus(4'b0001, 4'b0001);
    apply_stimulus(4'b0111, 4'b0001);
    apply_stimulus(4'b1000, 4'b0000);
    apply_stimulus(4'b1000, 4'b1000);
    apply_stimulus(4'b1000, 4'b1000);
    apply_stimulus(4'b0000, 4'b0000);
    apply_stimulus(4'b0000, 4'b0000);

    // Mid-tenure asynchronous reset while requester 2 owns, then release into req=0101.
    reset_dut();
    repeat (3) apply_stimulus(4'b0100, 4'b0100);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_output("async_enable", {4'b0, enable}, 8'h00);
    check_output("async_busy", {7'b0, busy}, 8'h00);
    check_output("async_owner", {6'b0, owner}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0101;
    push_exp(4'b0001);
    apply_stimulus(4'b0101, 4'b0001);
    apply_stimulus(4'b0100, 4'b0000);
    apply_stimulus(4'b0100, 4'b0100);
    apply_stimulus(4'b0000, 4'b0000);
    apply_stimulus(4'b0000, 4'b0000);

    @(negedge clk);
    @(negedge clk);
    check_output("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
